vga_pattern_gen: RTL and testbench

//  Parametrised, registered test-pattern generator for the VGA path. Consumes the

---
 rtl/vga_pattern_gen_pkg.sv | 38 +++
 rtl/vga_pattern_gen_if.sv | 27 ++
 rtl/vga_pattern_gen_box_fsm.sv | 50 +++++
 rtl/vga_pattern_gen.sv | 178 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the VGA test-pattern generator and its overlay users:
// mode codes, box direction states and the colour-bar table.
package vga_pattern_gen_pkg;

    typedef enum logic [2:0] {
        MODE_BLACK  = 3'd0,
        MODE_GRAD   = 3'd1,
        MODE_BARS   = 3'd2,
        MODE_CHECK  = 3'd3,
        MODE_SOLID  = 3'd4,
        MODE_SCROLL = 3'd5,
        MODE_BOX    = 3'd6,
        MODE_RSVD   = 3'd7
    } mode_e;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    // Bar colours as {R,G,B} on/off bits, left to right.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] c;
        c = 3'b000;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the timing generator, the pattern
// generator and the DAC driver.
interface vga_pattern_gen_if #(
    parameter int CW = 8,
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          VIDON;
    logic [HW-1:0] HC;
    logic [VW-1:0] VC;
    logic [17:0]   SW;
    logic [CW-1:0] R;
    logic [CW-1:0] G;
    logic [CW-1:0] B;
    logic          VID_Q;
    logic [7:0]    FRAME;

    modport master (
        output VIDON, HC, VC, SW,
        input  R, G, B, VID_Q, FRAME
    );

    modport slave (
        input  VIDON, HC, VC, SW,
        output R, G, B, VID_Q, FRAME
    );
endinterface

// File: rtl/vga_pattern_gen_box_fsm.sv
// One axis of the bouncing box: a position that ping-pongs between 0
// and LIMIT, turning on the step that reaches either end.
module vga_box_fsm
    import vga_pattern_gen_pkg::*;
#(
    parameter int LIMIT = 608,
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_i,
    output logic [WIDTH-1:0] pos_o
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    dir_e             state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DIR_INC;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (step_i) begin
            unique case (state_q)
                DIR_INC: begin
                    pos_d = pos_q + WIDTH'(1);
                    if (pos_d == LIM) state_d = DIR_DEC;
                end
                DIR_DEC: begin
                    pos_d = pos_q - WIDTH'(1);
                    if (pos_d == '0) state_d = DIR_INC;
                end
                default: ;
            endcase
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage registered test-pattern generator: stage 1 captures the pixel
// position and the frame-latched settings, stage 2 registers the colour.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int CW       = 8,
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX      = 32
) (
    input  logic CLK,
    input  logic RST_N,
    vga_pattern_gen_if.slave vif
);

    logic          vid1_q;
    logic [HW-1:0] hc1_q;
    logic [VW-1:0] vc1_q;
    mode_e         mode_q, mode_d;
    logic [2:0]    shift_q, shift_d;
    logic [11:0]   solid_q, solid_d;
    logic [7:0]    frame_q, frame_d;

    logic          vid2_q;
    logic [CW-1:0] r_q, g_q, b_q;
    logic [CW-1:0] r_d, g_d, b_d;

    logic          frame_bnd;
    logic          box_step;
    logic [HW-1:0] bx;
    logic [VW-1:0] by;
    logic          in_box;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_c;
    logic [3:0]    chk_sft;
    logic [HW-1:0] hc_sh;
    logic [VW-1:0] vc_sh;
    logic          tile;

    function automatic logic [CW-1:0] rep_nibble(input logic [3:0] n);
        logic [CW-1:0] v;
        v = '0;
        for (int i = 0; i < CW; i++) v[CW-1-i] = n[3-(i%4)];
        return v;
    endfunction

    assign frame_bnd = (vif.HC == '0) && (vif.VC == '0);
    // Step decision uses the mode being latched on this boundary.
    assign box_step  = frame_bnd && (vif.SW[17:15] == MODE_BOX);

    always_comb begin
        mode_d  = mode_q;
        shift_d = shift_q;
        solid_d = solid_q;
        frame_d = frame_q;
        if (frame_bnd) begin
            mode_d  = mode_e'(vif.SW[17:15]);
            shift_d = vif.SW[14:12];
            solid_d = vif.SW[11:0];
            frame_d = frame_q + 8'd1;
        end
    end

    vga_box_fsm #(.LIMIT(H_ACTIVE - BOX), .WIDTH(HW)) u_box_x (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .step_i (box_step),
        .pos_o  (bx)
    );

    vga_box_fsm #(.LIMIT(V_ACTIVE - BOX), .WIDTH(VW)) u_box_y (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .step_i (box_step),
        .pos_o  (by)
    );

    // Comparator chain instead of a divide; anything past the last bar saturates.
    always_comb begin
        bar_idx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (int'(hc1_q) < ((i + 1) * H_ACTIVE) / 8) bar_idx = 3'(i);
        end
    end

    assign bar_c   = bar_rgb(bar_idx);
    assign chk_sft = {1'b0, shift_q} + 4'd2;
    assign hc_sh   = hc1_q >> chk_sft;
    assign vc_sh   = vc1_q >> chk_sft;
    assign tile    = hc_sh[0] ^ vc_sh[0];

    assign in_box = (int'(hc1_q) >= int'(bx)) &&
                    (int'(hc1_q) <  int'(bx) + BOX) &&
                    (int'(vc1_q) >= int'(by)) &&
                    (int'(vc1_q) <  int'(by) + BOX);

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (vid1_q) begin
            case (mode_q)
                MODE_GRAD: begin
                    r_d = CW'(hc1_q);
                    g_d = CW'(vc1_q);
                    b_d = CW'(vc1_q);
                end
                MODE_BARS: begin
                    r_d = {CW{bar_c[2]}};
                    g_d = {CW{bar_c[1]}};
                    b_d = {CW{bar_c[0]}};
                end
                MODE_CHECK: begin
                    r_d = {CW{tile}};
                    g_d = {CW{tile}};
                    b_d = {CW{tile}};
                end
                MODE_SOLID: begin
                    r_d = rep_nibble(solid_q[11:8]);
                    g_d = rep_nibble(solid_q[7:4]);
                    b_d = rep_nibble(solid_q[3:0]);
                end
                MODE_SCROLL: begin
                    r_d = CW'(hc1_q) + CW'(frame_q);
                    g_d = CW'(vc1_q);
                    b_d = CW'(hc1_q) - CW'(frame_q);
                end
                MODE_BOX: begin
                    if (in_box) begin
                        r_d = '1;
                        g_d = '1;
                        b_d = '1;
                    end else begin
                        b_d[CW-1] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vid1_q  <= 1'b0;
            hc1_q   <= '0;
            vc1_q   <= '0;
            mode_q  <= MODE_BLACK;
            shift_q <= '0;
            solid_q <= '0;
            frame_q <= '0;
            vid2_q  <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            vid1_q  <= vif.VIDON;
            hc1_q   <= vif.HC;
            vc1_q   <= vif.VC;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            solid_q <= solid_d;
            frame_q <= frame_d;
            vid2_q  <= vid1_q;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign vif.R     = r_q;
    assign vif.G     = g_q;
    assign vif.B     = b_q;
    assign vif.VID_Q = vid2_q;
    assign vif.FRAME = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed corner cases plus random pixel streams
// compared against a frame-level reference model of the pattern rules.
module tb_vga_pattern_gen;

    logic CLK;
    logic RST_N;

    vga_pattern_gen_if #(.CW(8), .HW(10), .VW(10)) vif ();

    vga_pattern_gen dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .vif   (vif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode, m_shift, m_solid, m_frame, m_nb;
    logic [31:0] prev_e;
    logic        prev_ok;

    int bar_r [8] = '{255, 255,   0,   0, 255, 255,   0, 0};
    int bar_g [8] = '{255, 255, 255, 255,   0,   0,   0, 0};
    int bar_b [8] = '{255,   0, 255,   0, 255,   0, 255, 0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_pix();
        return {7'd0, vif.VID_Q, vif.R, vif.G, vif.B};
    endfunction

    function automatic logic [31:0] rgb(input int r, input int g, input int b);
        return {8'd0, 8'(r), 8'(g), 8'(b)};
    endfunction

    // Position after n steps of a 0..lim..0 triangle wave.
    function automatic int tri_pos(input int n, input int lim);
        int m;
        m = n % (2 * lim);
        return (m <= lim) ? m : 2 * lim - m;
    endfunction

    function automatic logic [31:0] model_pix(input logic vid, input int hc,
                                               input int vc);
        int r, g, b, s, t, idx, bx, by;
        r = 0; g = 0; b = 0;
        if (vid) begin
            case (m_mode)
                1: begin r = hc % 256; g = vc % 256; b = g; end
                2: begin
                    idx = hc * 8 / 640;
                    if (idx > 7) idx = 7;
                    r = bar_r[idx]; g = bar_g[idx]; b = bar_b[idx];
                end
                3: begin
                    s = m_shift + 2;
                    t = ((hc >> s) ^ (vc >> s)) & 1;
                    r = t * 255; g = r; b = r;
                end
                4: begin
                    r = ((m_solid >> 8) & 15) * 17;
                    g = ((m_solid >> 4) & 15) * 17;
                    b = (m_solid & 15) * 17;
                end
                5: begin
                    r = (hc + m_frame) & 255;
                    g = vc & 255;
                    b = (hc - m_frame) & 255;
                end
                6: begin
                    bx = tri_pos(m_nb, 608);
                    by = tri_pos(m_nb, 448);
                    if (hc >= bx && hc < bx + 32 && vc >= by && vc < by + 32) begin
                        r = 255; g = 255; b = 255;
                    end else begin
                        b = 128;
                    end
                end
                default: ;
            endcase
        end
        return {7'd0, vid, 8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic step(input logic vid, input int hc, input int vc);
        logic [31:0] e;
        hc = hc & 1023;
        vc = vc & 1023;
        vif.VIDON = vid;
        vif.HC    = 10'(hc);
        vif.VC    = 10'(vc);
        if (hc == 0 && vc == 0) begin
            m_mode  = int'(vif.SW[17:15]);
            m_shift = int'(vif.SW[14:12]);
            m_solid = int'(vif.SW[11:0]);
            m_frame = (m_frame + 1) % 256;
            if (m_mode == 6) m_nb++;
        end
        e = model_pix(vid, hc, vc);
        @(posedge CLK);
        #1;
        if (prev_ok) check("pix", dut_pix(), prev_e);
        check("frame", 32'(vif.FRAME), 32'(m_frame));
        prev_e  = e;
        prev_ok = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        #2 RST_N = 1'b0;
        #1;
        check("rst_async_pix", dut_pix(), 32'd0);
        check("rst_async_frame", 32'(vif.FRAME), 32'd0);
        for (int i = 0; i < cycles; i++) begin
            vif.VIDON = 1'b1;
            vif.HC    = 10'($urandom);
            vif.VC    = 10'($urandom);
            vif.SW    = 18'($urandom);
            @(posedge CLK);
            #1;
            check("rst_hold_pix", dut_pix(), 32'd0);
            check("rst_hold_frame", 32'(vif.FRAME), 32'd0);
        end
        m_mode = 0; m_shift = 0; m_solid = 0; m_frame = 0; m_nb = 0;
        prev_e  = 32'd0;
        prev_ok = 1'b1;
        RST_N   = 1'b1;
    endtask

    task automatic probe(input int h, input int v);
        h = h & 1023;
        v = v & 1023;
        if (h == 0 && v == 0) h = 1;
        step(1'b1, h, v);
    endtask

    initial begin
        int bx, by;
        RST_N     = 1'b1;
        vif.VIDON = 1'b1;
        vif.HC    = 10'd5;
        vif.VC    = 10'd5;
        vif.SW    = 18'd0;
        prev_ok   = 1'b0;
        prev_e    = 32'd0;
        m_mode = 0; m_shift = 0; m_solid = 0; m_frame = 0; m_nb = 0;

        do_reset(3);

        // gradient
        vif.SW = {3'd1, 15'd0};
        step(1'b1, 0, 0);
        step(1'b1, 300, 200);
        step(1'b1, 10, 10);
        check("grad", dut_pix(), {7'd0, 1'b1, 8'h2C, 8'hC8, 8'hC8});
        step(1'b0, 300, 200);
        step(1'b1, 5, 5);
        check("vidon_off", dut_pix(), 32'd0);

        // bars
        vif.SW = {3'd2, 15'd0};
        step(1'b1, 0, 0);
        step(1'b1, 0, 5);
        step(1'b1, 80, 5);
        check("bar_white", 32'({vif.R, vif.G, vif.B}), rgb(255, 255, 255));
        step(1'b1, 639, 5);
        check("bar_yellow", 32'({vif.R, vif.G, vif.B}), rgb(255, 255, 0));
        step(1'b1, 1000, 5);
        check("bar_black", dut_pix(), {7'd0, 1'b1, 24'd0});
        step(1'b1, 1, 5);
        check("bar_sat", dut_pix(), {7'd0, 1'b1, 24'd0});

        // checker, smallest tile
        vif.SW = {3'd3, 3'd0, 12'd0};
        step(1'b1, 0, 0);
        step(1'b1, 4, 0);
        step(1'b1, 4, 4);
        check("chk_one", 32'({vif.R, vif.G, vif.B}), rgb(255, 255, 255));
        step(1'b1, 9, 9);
        check("chk_zero", 32'({vif.R, vif.G, vif.B}), rgb(0, 0, 0));

        // solid, then mid-frame switch to black
        vif.SW = {3'd4, 3'd0, 12'hF80};
        step(1'b1, 0, 0);
        step(1'b1, 100, 100);
        step(1'b1, 200, 50);
        check("solid", 32'({vif.R, vif.G, vif.B}), rgb(255, 136, 0));
        vif.SW = 18'd0;
        step(1'b1, 300, 100);
        step(1'b1, 5, 5);
        check("solid_hold", 32'({vif.R, vif.G, vif.B}), rgb(255, 136, 0));
        check("frame_hold", 32'(vif.FRAME), 32'd4);
        step(1'b1, 0, 0);
        step(1'b1, 7, 7);
        check("black_after_bnd", dut_pix(), {7'd0, 1'b1, 24'd0});
        check("frame_once", 32'(vif.FRAME), 32'd5);

        // random modes, random pixels, mid-frame switch noise
        for (int f = 0; f < 40; f++) begin
            vif.SW = 18'($urandom);
            step($urandom_range(0, 3) != 0, 0, 0);
            for (int p = 0; p < 40; p++) begin
                vif.SW = 18'($urandom);
                if (p[0])
                    step($urandom_range(0, 3) != 0, $urandom_range(0, 639),
                         $urandom_range(0, 479));
                else
                    step($urandom_range(0, 3) != 0, $urandom_range(0, 1023),
                         $urandom_range(0, 1023));
                if (f == 20 && p == 15) do_reset(1);
            end
        end

        // bouncing box over many frames
        do_reset(2);
        vif.SW = {3'd6, 15'd0};
        for (int f = 0; f < 1000; f++) begin
            step(1'b1, 0, 0);
            bx = tri_pos(m_nb, 608);
            by = tri_pos(m_nb, 448);
            probe(bx, by);
            probe(bx - 1, by);
            probe(bx + 31, by + 31);
            probe(bx + 32, by + 31);
            probe(bx + 31, by + 32);
            probe(bx, by - 1);
            if (m_nb == 608) begin
                probe(608, 288);
                probe(607, 288);
                check("box_x_turn_in", 32'({vif.R, vif.G, vif.B}), rgb(255, 255, 255));
                probe(1, 1);
                check("box_x_turn_out", 32'({vif.R, vif.G, vif.B}), rgb(0, 0, 128));
            end
            if (m_nb == 448) begin
                probe(448, 448);
                probe(448, 447);
                check("box_y_turn_in", 32'({vif.R, vif.G, vif.B}), rgb(255, 255, 255));
                probe(1, 1);
                check("box_y_turn_out", 32'({vif.R, vif.G, vif.B}), rgb(0, 0, 128));
            end
        end
        step(1'b0, 5, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
